// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types for the sampling / NTT-domain datapath.
package kyber_pkg;

    localparam logic [11:0] KYBER_Q = 12'd3329;
    localparam int          KYBER_N = 256;
    localparam int          COEFF_W = 12;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_WAIT_BLK,
        RS_SAMPLE,
        RS_DONE
    } rs_state_t;

endpackage

// File: rtl/rs_triple_parse.sv
// Splits one 3-byte group of XOF output into two 12-bit candidates and flags
// which of them fall inside [0, q).
module rs_triple_parse
    import kyber_pkg::*;
(
    input  logic [23:0] triple,
    output coeff_t      d1,
    output coeff_t      d2,
    output logic        d1_ok,
    output logic        d2_ok
);

    // b0 = triple[7:0], b1 = triple[15:8], b2 = triple[23:16]
    assign d1    = triple[11:0];   // {b1[3:0], b0}
    assign d2    = triple[23:12];  // {b2, b1[7:4]}
    assign d1_ok = d1 < KYBER_Q;
    assign d2_ok = d2 < KYBER_Q;

endmodule

// File: rtl/rej_sample_ntt.sv
// Kyber uniform rejection sampler: consumes squeezed SHAKE128 rate blocks and
// emits 256 indexed coefficients in [0, q), one candidate evaluated per cycle.
module rej_sample_ntt
    import kyber_pkg::*;
#(
    parameter int R          = 1344,
    parameter int MAX_BLOCKS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          blk_req,
    input  logic          blk_valid,
    output logic          blk_ready,
    input  logic [R-1:0]  blk_data,
    output logic          coeff_valid,
    output logic [11:0]   coeff,
    output logic [7:0]    coeff_idx,
    output logic          done,
    output logic          fail
);

    localparam int NTRI = R / 24;
    localparam int TW   = $clog2(NTRI);
    localparam int BW   = $clog2(MAX_BLOCKS + 1);

    rs_state_t     state;
    logic [R-1:0]  sreg;
    logic          phase;
    logic [TW-1:0] tri_cnt;
    logic [8:0]    cnt;
    logic [BW-1:0] blk_cnt;

    coeff_t d1, d2, cand;
    logic   d1_ok, d2_ok, cand_ok;
    logic   last_cand, last_coeff, blocks_gone;

    rs_triple_parse u_parse (
        .triple (sreg[23:0]),
        .d1     (d1),
        .d2     (d2),
        .d1_ok  (d1_ok),
        .d2_ok  (d2_ok)
    );

    assign cand        = phase ? d2 : d1;
    assign cand_ok     = phase ? d2_ok : d1_ok;
    assign last_cand   = phase && (tri_cnt == TW'(NTRI - 1));
    assign last_coeff  = cand_ok && (cnt == 9'(KYBER_N - 1));
    assign blocks_gone = blk_cnt == BW'(MAX_BLOCKS);

    assign blk_req   = state == RS_WAIT_BLK;
    assign blk_ready = state == RS_WAIT_BLK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RS_IDLE;
            sreg        <= '0;
            phase       <= 1'b0;
            tri_cnt     <= '0;
            cnt         <= '0;
            blk_cnt     <= '0;
            coeff_valid <= 1'b0;
            coeff       <= '0;
            coeff_idx   <= '0;
            done        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            coeff_valid <= 1'b0;
            case (state)
                RS_IDLE, RS_DONE: begin
                    if (start) begin
                        state   <= RS_WAIT_BLK;
                        done    <= 1'b0;
                        fail    <= 1'b0;
                        cnt     <= '0;
                        blk_cnt <= '0;
                    end
                end
                RS_WAIT_BLK: begin
                    if (blk_valid) begin
                        sreg    <= blk_data;
                        blk_cnt <= blk_cnt + 1'b1;
                        phase   <= 1'b0;
                        tri_cnt <= '0;
                        state   <= RS_SAMPLE;
                    end
                end
                RS_SAMPLE: begin
                    if (cand_ok) begin
                        coeff_valid <= 1'b1;
                        coeff       <= cand;
                        coeff_idx   <= cnt[7:0];
                        cnt         <= cnt + 1'b1;
                    end
                    phase <= ~phase;
                    if (phase) begin
                        sreg    <= sreg >> 24;
                        tri_cnt <= tri_cnt + 1'b1;
                    end
                    // A full polynomial wins over block exhaustion on the same candidate.
                    if (last_coeff) begin
                        state <= RS_DONE;
                        done  <= 1'b1;
                    end else if (last_cand) begin
                        if (blocks_gone) begin
                            state <= RS_DONE;
                            done  <= 1'b1;
                            fail  <= 1'b1;
                        end else begin
                            state <= RS_WAIT_BLK;
                        end
                    end
                end
                default: state <= RS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rej_sample_ntt.sv
// Bench for rej_sample_ntt: table of block patterns plus randomized runs,
// all checked against a byte-level model of Kyber's Parse, and hand sequences.
module tb_rej_sample_ntt;

    localparam int R    = 1344;
    localparam int MAXB = 4;
    localparam int NB   = R / 8;
    localparam int NT   = R / 24;

    logic          clk = 1'b0;
    logic          rst, start, blk_valid;
    logic [R-1:0]  blk_data;
    logic          blk_req, blk_ready, coeff_valid, done, fail;
    logic [11:0]   coeff;
    logic [7:0]    coeff_idx;

    rej_sample_ntt #(.R(R), .MAX_BLOCKS(MAXB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .blk_req(blk_req), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .coeff_valid(coeff_valid), .coeff(coeff), .coeff_idx(coeff_idx),
        .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] bytes_m [MAXB][NB];
    int exp_c[$];
    int exp_nblk, exp_fail;
    int got_c[$];
    int got_i[$];
    int nhs;

    typedef struct {
        int pat;        // 0 zero, 1 ones, 2 early-stop, 3 boundary, 4 random, 5 reject-heavy
        int stall;
        int mid_start;
        int exp_cnt;    // -1: rely on the model only
        int exp_nblk;
        int exp_fail;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int b = 0; b < MAXB; b++)
            for (int j = 0; j < NB; j++) begin
                case (pat)
                    1:       bytes_m[b][j] = 8'hFF;
                    4:       bytes_m[b][j] = 8'($urandom);
                    default: bytes_m[b][j] = 8'h00;
                endcase
            end
        if (pat == 2) begin
            bytes_m[0][150] = 8'h02; bytes_m[0][151] = 8'h00; bytes_m[0][152] = 8'h03;
        end
        if (pat == 3) begin
            bytes_m[0][0] = 8'h01; bytes_m[0][1] = 8'h0D; bytes_m[0][2] = 8'h00;
            bytes_m[0][3] = 8'h00; bytes_m[0][4] = 8'h0D; bytes_m[0][5] = 8'h00;
        end
        if (pat == 5) begin
            for (int b = 0; b < MAXB; b++)
                for (int t = 0; t < NT; t++) begin
                    bytes_m[b][3*t]   = 8'($urandom);
                    bytes_m[b][3*t+1] = 8'($urandom);
                    bytes_m[b][3*t+2] = 8'($urandom);
                    if ($urandom_range(9) != 0) begin
                        bytes_m[b][3*t+1] = bytes_m[b][3*t+1] | 8'h0F;
                        bytes_m[b][3*t+2] = bytes_m[b][3*t+2] | 8'hD0;
                    end
                end
        end
    endtask

    // Parse over a byte stream: two 12-bit little-endian values per 3 bytes.
    function automatic void model();
        int b0, b1, b2, d1, d2;
        exp_c.delete();
        exp_nblk = 0;
        for (int b = 0; b < MAXB && exp_c.size() < 256; b++) begin
            exp_nblk++;
            for (int t = 0; t < NT && exp_c.size() < 256; t++) begin
                b0 = int'(bytes_m[b][3*t]);
                b1 = int'(bytes_m[b][3*t+1]);
                b2 = int'(bytes_m[b][3*t+2]);
                d1 = b0 + 256 * (b1 % 16);
                d2 = b1 / 16 + 16 * b2;
                if (d1 < 3329) exp_c.push_back(d1);
                if (exp_c.size() < 256 && d2 < 3329) exp_c.push_back(d2);
            end
        end
        exp_fail = (exp_c.size() < 256) ? 1 : 0;
    endfunction

    task automatic pack(input int b);
        for (int j = 0; j < NB; j++) blk_data[8*j +: 8] = bytes_m[b][j];
    endtask

    task automatic run(input int stall, input int mid_start);
        int  cyc = 0;
        int  stall_left = stall;
        bit  seen_start = 0;
        bit  fin = 0;
        model();
        got_c.delete(); got_i.delete(); nhs = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!fin && cyc < 3000) begin
            if (coeff_valid) begin
                got_c.push_back(int'(coeff));
                got_i.push_back(int'(coeff_idx));
            end
            if (done) fin = 1;
            else begin
                start = 1'b0;
                if (mid_start != 0 && got_c.size() == 5 && !seen_start) begin
                    start = 1'b1; seen_start = 1;
                end
                if (blk_req) begin
                    if (stall_left > 0) begin
                        stall_left--; blk_valid = 1'b0;
                    end else begin
                        blk_valid = 1'b1;
                        pack(nhs < MAXB ? nhs : MAXB - 1);
                        nhs++;
                    end
                end else blk_valid = 1'b0;
                @(negedge clk); cyc++;
            end
        end
        start = 1'b0; blk_valid = 1'b0;
        chk("run_terminates", 32'(fin), 32'd1);
        chk("coeff_count", 32'(got_c.size()), 32'(exp_c.size()));
        for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) begin
            chk($sformatf("coeff[%0d]", i), 32'(got_c[i]), 32'(exp_c[i]));
            chk($sformatf("coeff_idx[%0d]", i), 32'(got_i[i]), 32'(i));
        end
        chk("blocks_consumed", 32'(nhs), 32'(exp_nblk));
        chk("fail_flag", 32'(fail), 32'(exp_fail));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done_held", 32'(done), 32'd1);
            chk("no_req_after_done", 32'(blk_req), 32'd0);
            chk("no_coeff_after_done", 32'(coeff_valid), 32'd0);
        end
    endtask

    vec_t vt[7];

    initial begin
        bit hit;
        vt[0] = '{pat: 0, stall: 0, mid_start: 0, exp_cnt: 256, exp_nblk: 3, exp_fail: 0};
        vt[1] = '{pat: 1, stall: 0, mid_start: 0, exp_cnt: 0,   exp_nblk: 4, exp_fail: 1};
        vt[2] = '{pat: 3, stall: 2, mid_start: 0, exp_cnt: 256, exp_nblk: 3, exp_fail: 0};
        vt[3] = '{pat: 2, stall: 0, mid_start: 1, exp_cnt: 256, exp_nblk: 3, exp_fail: 0};
        vt[4] = '{pat: 0, stall: 0, mid_start: 1, exp_cnt: 256, exp_nblk: 3, exp_fail: 0};
        vt[5] = '{pat: 4, stall: 3, mid_start: 1, exp_cnt: -1,  exp_nblk: -1, exp_fail: -1};
        vt[6] = '{pat: 5, stall: 0, mid_start: 0, exp_cnt: -1,  exp_nblk: -1, exp_fail: -1};

        rst = 1'b1; start = 1'b0; blk_valid = 1'b0; blk_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_coeff_valid", 32'(coeff_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_blk_req", 32'(blk_req), 32'd0);
        chk("rst_blk_ready", 32'(blk_ready), 32'd0);
        rst = 1'b0;

        // Stall in WAIT_BLK, first-coefficient latency, then reset mid-run at cnt 40.
        fill(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("stall_blk_req", 32'(blk_req), 32'd1);
            chk("stall_no_coeff", 32'(coeff_valid), 32'd0);
            @(negedge clk);
        end
        blk_valid = 1'b1; pack(0);
        @(negedge clk); blk_valid = 1'b0;
        chk("latency_t1", 32'(coeff_valid), 32'd0);
        @(negedge clk);
        chk("latency_t2", 32'(coeff_valid), 32'd1);
        chk("latency_idx0", 32'(coeff_idx), 32'd0);
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (coeff_valid && coeff_idx == 8'd39) hit = 1;
            else @(negedge clk);
        end
        chk("reached_idx39", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_coeff_valid", 32'(coeff_valid), 32'd0);
        chk("midrst_coeff", 32'(coeff), 32'd0);
        chk("midrst_coeff_idx", 32'(coeff_idx), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_blk_req", 32'(blk_req), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_no_coeff", 32'(coeff_valid), 32'd0);
            chk("idle_no_req", 32'(blk_req), 32'd0);
        end

        // Table of patterns, run back-to-back from DONE.
        for (int v = 0; v < 7; v++) begin
            fill(vt[v].pat);
            run(vt[v].stall, vt[v].mid_start);
            if (vt[v].exp_cnt >= 0) begin
                chk($sformatf("vec%0d_count", v), 32'(got_c.size()), 32'(vt[v].exp_cnt));
                chk($sformatf("vec%0d_blocks", v), 32'(nhs), 32'(vt[v].exp_nblk));
                chk($sformatf("vec%0d_fail", v), 32'(fail), 32'(vt[v].exp_fail));
            end
            if (vt[v].pat == 3 && got_c.size() >= 2) begin
                chk("boundary_d2_zero", 32'(got_c[0]), 32'd0);
                chk("boundary_3328", 32'(got_c[1]), 32'd3328);
            end
            if (vt[v].pat == 2 && got_c.size() >= 102) begin
                chk("early_idx100", 32'(got_c[100]), 32'd2);
                chk("early_idx101", 32'(got_c[101]), 32'd48);
            end
        end

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            fill($urandom_range(1) == 0 ? 4 : 5);
            run(int'($urandom_range(4)), int'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
